wt_mem_responder: RTL and testbench

- Memory-side responder for the write-through dcache memory request/return interface: the far end of the interface that the WT dcache drives as initiator.
- Accepts load and store requests tagged with a transaction ID and returns in-order responses after a programmable fixed latency.
- Backed by a small internal word-addressed RAM.
- Used in FPGA and simulation harnesses in place of the AXI adapter, for cache bring-up and for verifying tid/ordering behaviour.

---
 rtl/wt_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_wt_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the WT dcache request/return interface: word RAM plus an in-order response queue.
// Define WT_MEM_RESPONDER_STALL_EN to add LFSR-driven random backpressure on both channels.
module wt_mem_responder #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MemTidWidth    = 2,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned Latency        = 3,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_we_i,
    input  logic [MemTidWidth-1:0]               req_tid_i,
    input  logic [AddrWidth-1:0]                 req_addr_i,
    input  logic [DataWidth-1:0]                 req_wdata_i,
    input  logic [DataWidth/8-1:0]               req_be_i,
    output logic                                 rtrn_valid_o,
    input  logic                                 rtrn_ready_i,
    output logic                                 rtrn_we_o,
    output logic [MemTidWidth-1:0]               rtrn_tid_o,
    output logic [DataWidth-1:0]                 rtrn_rdata_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned OffW    = $clog2(BeWidth);
    localparam int unsigned IdxW    = $clog2(MemWords);
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CdW     = (Latency > 1) ? $clog2(Latency) : 1;
    localparam int          Depth   = int'(MaxOutstanding);
    localparam int          NumBe   = int'(BeWidth);

    localparam logic [CdW-1:0]  CdInit  = CdW'(Latency - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);

    logic [DataWidth-1:0]         r_mem [MemWords];
    logic                         r_qWe [Depth];
    logic [MemTidWidth-1:0]       r_qTid [Depth];
    logic [DataWidth-1:0]         r_qData [Depth];
    logic [Depth-1:0][CdW-1:0]    r_qCd;
    logic [PtrW-1:0]              r_wrPtr;
    logic [PtrW-1:0]              r_rdPtr;
    logic [CntW-1:0]              r_count;

    logic [IdxW-1:0]              w_idx;
    logic [DataWidth-1:0]         w_rdata;
    logic [DataWidth-1:0]         w_wmerge;
    logic                         w_headReady;
    logic                         w_rtrnValid;
    logic                         w_reqReady;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_unused;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign w_idx    = req_addr_i[OffW +: IdxW];
    assign w_unused = ^{req_addr_i[AddrWidth-1:OffW+IdxW], req_addr_i[OffW-1:0]};

    // Combinational read: a load sees the RAM as it was before this cycle's store.
    assign w_rdata = r_mem[w_idx];

    always_comb begin
        w_wmerge = w_rdata;
        for (int b = 0; b < NumBe; b++) begin
            if (req_be_i[b]) begin
                w_wmerge[b*8 +: 8] = req_wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && req_we_i && (req_be_i != '0)) begin
            r_mem[w_idx] <= w_wmerge;
        end
    end

    assign w_headReady = (r_count != '0) && (r_qCd[r_rdPtr] == '0);

`ifdef WT_MEM_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;
    logic        r_presented;
    logic        w_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr      <= 16'hACE1;
            r_presented <= 1'b0;
        end else begin
            r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_presented <= w_rtrnValid & ~rtrn_ready_i;
        end
    end

    // A stall only delays a fresh response; one already on the bus stays up.
    assign w_stall     = r_lfsr[0];
    assign w_rtrnValid = w_headReady & (~w_stall | r_presented);
    assign w_reqReady  = (r_count < CntMax) & ~w_stall;
`else
    assign w_rtrnValid = w_headReady;
    assign w_reqReady  = (r_count < CntMax);
`endif

    assign w_push = req_valid_i & w_reqReady;
    assign w_pop  = w_rtrnValid & rtrn_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ptrInc(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= ptrInc(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Countdowns run regardless of backpressure; free slots are overwritten on push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_qCd <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (r_qCd[i] != '0) begin
                    r_qCd[i] <= r_qCd[i] - 1'b1;
                end
            end
            if (w_push) begin
                r_qCd[r_wrPtr] <= CdInit;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_qWe[r_wrPtr]   <= req_we_i;
            r_qTid[r_wrPtr]  <= req_tid_i;
            r_qData[r_wrPtr] <= req_we_i ? '0 : w_rdata;
        end
    end

    assign req_ready_o   = w_reqReady;
    assign rtrn_valid_o  = w_rtrnValid;
    assign rtrn_we_o     = w_rtrnValid & r_qWe[r_rdPtr];
    assign rtrn_tid_o    = w_rtrnValid ? r_qTid[r_rdPtr] : '0;
    assign rtrn_rdata_o  = w_rtrnValid ? r_qData[r_rdPtr] : '0;
    assign outstanding_o = r_count;

endmodule

// File: tb/tb_wt_mem_responder.sv
// Self-checking bench for wt_mem_responder: directed steps and a random phase checked against
// a word-array memory model and an ordered queue of expected responses.
module tb_wt_mem_responder;

    localparam int Lat    = 3;
    localparam int MaxOut = 4;
    localparam int Words  = 1024;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_tid_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic [7:0]  req_be_i = '0;
    logic        rtrn_valid_o;
    logic        rtrn_ready_i = 1'b0;
    logic        rtrn_we_o;
    logic [1:0]  rtrn_tid_o;
    logic [63:0] rtrn_rdata_o;
    logic [2:0]  outstanding_o;

    always #5 clk_i = ~clk_i;

    wt_mem_responder #(
        .AddrWidth(64), .DataWidth(64), .MemTidWidth(2),
        .MemWords(Words), .Latency(Lat), .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_tid_i(req_tid_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_be_i(req_be_i), .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready_i),
        .rtrn_we_o(rtrn_we_o), .rtrn_tid_o(rtrn_tid_o), .rtrn_rdata_o(rtrn_rdata_o),
        .outstanding_o(outstanding_o)
    );

    typedef struct {
        logic        we;
        logic [1:0]  tid;
        logic [63:0] data;
        int          acceptCyc;
    } resp_t;

    resp_t       expQ[$];
    logic [63:0] memModel [Words];
    logic [1:0]  popTids[$];
    logic [63:0] lastPopData = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pushCount = 0;
    int          popCount = 0;
    logic        lastPush = 1'b0;
    logic        hold = 1'b0;
    logic        holdWe = 1'b0;
    logic [1:0]  holdTid = '0;
    logic [63:0] holdData = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wordIndex(input logic [63:0] addr);
        return int'((addr / 64'd8) % 64'(Words));
    endfunction

    // Compare DUT outputs for the current cycle, then advance the model by the handshakes about to happen.
    task automatic checkOutput();
        int    occ;
        int    idx;
        logic  eligible;
        resp_t item;
        occ = expQ.size();
        eligible = 1'b0;
        if (occ > 0) eligible = (cyc >= expQ[0].acceptCyc + Lat);

        chk("outstanding", 64'(outstanding_o), 64'(occ));
`ifndef WT_MEM_RESPONDER_STALL_EN
        chk("rtrn_valid", 64'(rtrn_valid_o), 64'(eligible));
        chk("req_ready", 64'(req_ready_o), 64'(occ < MaxOut));
`else
        if (rtrn_valid_o) chk("valid_eligible", 64'(eligible), 64'd1);
        if (req_ready_o) chk("ready_room", 64'(occ < MaxOut), 64'd1);
`endif
        if (rtrn_valid_o && occ > 0) begin
            chk("rtrn_we", 64'(rtrn_we_o), 64'(expQ[0].we));
            chk("rtrn_tid", 64'(rtrn_tid_o), 64'(expQ[0].tid));
            chk("rtrn_rdata", rtrn_rdata_o, expQ[0].data);
        end
        if (hold) begin
            chk("hold_valid", 64'(rtrn_valid_o), 64'd1);
            chk("hold_we", 64'(rtrn_we_o), 64'(holdWe));
            chk("hold_tid", 64'(rtrn_tid_o), 64'(holdTid));
            chk("hold_rdata", rtrn_rdata_o, holdData);
        end
        hold     = rtrn_valid_o && !rtrn_ready_i && !rst_i;
        holdWe   = rtrn_we_o;
        holdTid  = rtrn_tid_o;
        holdData = rtrn_rdata_o;

        lastPush = 1'b0;
        if (rst_i) begin
            expQ.delete();
        end else begin
            if (rtrn_valid_o && rtrn_ready_i) begin
                popTids.push_back(rtrn_tid_o);
                lastPopData = rtrn_rdata_o;
                if (occ > 0) begin
                    item = expQ.pop_front();
                    popCount++;
                end
            end
            if (req_valid_i && req_ready_o) begin
                idx = wordIndex(req_addr_i);
                item.we = req_we_i;
                item.tid = req_tid_i;
                item.acceptCyc = cyc;
                if (req_we_i) begin
                    item.data = '0;
                    for (int b = 0; b < 8; b++) begin
                        if (req_be_i[b]) memModel[idx][b*8 +: 8] = req_wdata_i[b*8 +: 8];
                    end
                end else begin
                    item.data = memModel[idx];
                end
                expQ.push_back(item);
                lastPush = 1'b1;
                pushCount++;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] tid,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] be, input logic rr, input logic rst);
        req_valid_i  = v;
        req_we_i     = we;
        req_tid_i    = tid;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_be_i     = be;
        rtrn_ready_i = rr;
        rst_i        = rst;
        #1;
        checkOutput();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 8'd0, rr, 1'b0);
    endtask

    task automatic sendReq(input logic we, input logic [1:0] tid, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] be, input logic rr,
                           output int acceptCyc);
        logic done;
        done = 1'b0;
        acceptCyc = cyc;
        for (int i = 0; i < 64 && !done; i++) begin
            acceptCyc = cyc;
            applyStimulus(1'b1, we, tid, addr, wdata, be, rr, 1'b0);
            done = lastPush;
        end
        chk("send_accepted", 64'(done), 64'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (expQ.size() > 0 || rtrn_valid_o); i++) idle(1'b1);
        chk("drained", 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkReset();
        chk("rst_valid", 64'(rtrn_valid_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_we", 64'(rtrn_we_o), 64'd0);
        chk("rst_tid", 64'(rtrn_tid_o), 64'd0);
        chk("rst_rdata", rtrn_rdata_o, 64'd0);
`ifndef WT_MEM_RESPONDER_STALL_EN
        chk("rst_ready", 64'(req_ready_o), 64'd1);
`endif
    endtask

    initial begin
        int          acc;
        int          lat;
        int          accepted;
        int          push0;
        int          pop0;
        logic [63:0] a;

        repeat (3) @(negedge clk_i);
        #1;
        checkReset();
        rst_i = 1'b0;

        // Fill words 0..15 with known data so every later load has a defined expectation.
        for (int w = 0; w < 16; w++) begin
            sendReq(1'b1, 2'(w), 64'(w * 8), {$urandom, $urandom}, 8'hFF, 1'b1, acc);
        end
        drain();

        $display("[TB] full store and ack latency");
        sendReq(1'b1, 2'd1, 64'h10, 64'h1122334455667788, 8'hFF, 1'b1, acc);
        for (int i = 0; i < 32 && !rtrn_valid_o; i++) idle(1'b1);
        lat = cyc - acc;
`ifndef WT_MEM_RESPONDER_STALL_EN
        chk("store_latency", 64'(lat), 64'(Lat));
`endif
        chk("ack_we", 64'(rtrn_we_o), 64'd1);
        chk("ack_tid", 64'(rtrn_tid_o), 64'd1);
        chk("ack_rdata", rtrn_rdata_o, 64'd0);
        drain();

        $display("[TB] partial store then load");
        sendReq(1'b1, 2'd0, 64'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b1, acc);
        sendReq(1'b0, 2'd2, 64'h10, 64'd0, 8'd0, 1'b1, acc);
        drain();
        chk("merge_tid", 64'(popTids[$]), 64'd2);
        chk("merge_data", lastPopData, 64'h11223344_BBBBBBBB);

        $display("[TB] fill queue under backpressure");
        popTids.delete();
        for (int t = 0; t < 4; t++) sendReq(1'b0, 2'(t), 64'(t * 8), 64'd0, 8'd0, 1'b0, acc);
        #1;
        chk("full_outstanding", 64'(outstanding_o), 64'd4);
        chk("full_ready", 64'(req_ready_o), 64'd0);
        repeat (4) idle(1'b0);
        idle(1'b1);
`ifndef WT_MEM_RESPONDER_STALL_EN
        chk("ready_after_pop", 64'(req_ready_o), 64'd1);
`endif
        drain();
        chk("order_count", 64'(popTids.size()), 64'd4);
        for (int t = 0; t < 4 && t < popTids.size(); t++) chk("order_tid", 64'(popTids[t]), 64'(t));

        $display("[TB] address wrap");
        sendReq(1'b0, 2'd3, 64'h10 + 64'(Words * 8), 64'd0, 8'd0, 1'b1, acc);
        drain();
        chk("wrap_data", lastPopData, 64'h11223344_BBBBBBBB);

        $display("[TB] reset with responses in flight");
        for (int t = 0; t < 3; t++) sendReq(1'b0, 2'(t), 64'(t * 8), 64'd0, 8'd0, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 8'd0, 1'b0, 1'b1);
        #1;
        checkReset();
        popTids.delete();
        repeat (10) idle(1'b1);
        chk("no_stale", 64'(popTids.size()), 64'd0);

        $display("[TB] random traffic");
        push0 = pushCount;
        pop0 = popCount;
        accepted = 0;
        for (int i = 0; i < 6000 && accepted < 200; i++) begin
            a = {$urandom, $urandom};
            a[12:3] = 10'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), a, {$urandom, $urandom}, 8'($urandom),
                          1'($urandom_range(0, 9) < 7), 1'b0);
            if (lastPush) accepted++;
        end
        chk("random_accepted", 64'(accepted), 64'd200);
        drain();
        chk("random_balance", 64'(popCount - pop0), 64'(pushCount - push0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
